// File: rtl/mem_burst_initiator.sv
// Burst-mode memory initiator: runs a line writeback, a line fill, or a writeback
// followed by a fill over a single-port delayed memory, with a per-phase timeout.
module mem_burst_initiator #(
  parameter int unsigned BURST_LEN      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ_READ,
  input  logic                    REQ_WRITE,
  input  logic [31:0]             REQ_ADDR,
  input  logic [31:0]             WB_ADDR,
  input  logic [32*BURST_LEN-1:0] WLINE,
  output logic [32*BURST_LEN-1:0] RLINE,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERR,
  output logic                    MEM_RE,
  output logic                    MEM_WE,
  output logic [31:0]             MEM_ADDR,
  output logic [31:0]             MEM_DOUT,
  input  logic [31:0]             MEM_DIN,
  input  logic                    MEM_VALID
);

  localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BeatW-1:0] LastBeat  = BeatW'(BURST_LEN - 1);
  localparam logic [TmoW-1:0]  TmoLimit  = TmoW'(TIMEOUT_CYCLES);
  localparam logic [29:0]      AlignMask = ~30'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWb,
    StGap,
    StFill,
    StDone
  } state_e;

  state_e                        state_q, state_d;
  logic [BeatW-1:0]              beat_q, beat_d;
  logic [TmoW-1:0]               tmo_q, tmo_d;
  logic [BURST_LEN-1:0][31:0]    wline_q, wline_d;
  logic [BURST_LEN-1:0][31:0]    rline_q, rline_d;
  logic [29:0]                   wb_base_q, wb_base_d;
  logic [29:0]                   rd_base_q, rd_base_d;
  logic                          fill_pend_q, fill_pend_d;
  logic                          err_q, err_d;

  // Byte-offset bits below the word are never needed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{REQ_ADDR[1:0], WB_ADDR[1:0]};

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    wline_d     = wline_q;
    rline_d     = rline_q;
    wb_base_d   = wb_base_q;
    rd_base_d   = rd_base_q;
    fill_pend_d = fill_pend_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (REQ_WRITE || REQ_READ) begin
          wline_d     = WLINE;
          wb_base_d   = WB_ADDR[31:2] & AlignMask;
          rd_base_d   = REQ_ADDR[31:2] & AlignMask;
          fill_pend_d = REQ_WRITE && REQ_READ;
          beat_d      = '0;
          tmo_d       = '0;
          state_d     = REQ_WRITE ? StWb : StFill;
        end
      end

      StWb, StFill: begin
        tmo_d = tmo_q + 1'b1;
        if (MEM_VALID) begin
          beat_d = beat_q + 1'b1;
          if (state_q == StFill) begin
            rline_d[beat_q] = MEM_DIN;
          end
        end
        // Completing the last beat wins over a timeout on the same edge.
        if (MEM_VALID && (beat_q == LastBeat)) begin
          beat_d      = '0;
          tmo_d       = '0;
          fill_pend_d = 1'b0;
          state_d     = ((state_q == StWb) && fill_pend_q) ? StGap : StDone;
        end else if (tmo_d == TmoLimit) begin
          beat_d      = '0;
          tmo_d       = '0;
          fill_pend_d = 1'b0;
          err_d       = 1'b1;
          state_d     = StDone;
        end
      end

      StGap: begin
        beat_d  = '0;
        tmo_d   = '0;
        state_d = StFill;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      tmo_q       <= '0;
      wline_q     <= '0;
      rline_q     <= '0;
      wb_base_q   <= '0;
      rd_base_q   <= '0;
      fill_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      wline_q     <= wline_d;
      rline_q     <= rline_d;
      wb_base_q   <= wb_base_d;
      rd_base_q   <= rd_base_d;
      fill_pend_q <= fill_pend_d;
      err_q       <= err_d;
    end
  end

  // Strobes decode straight from the state register, so they never glitch.
  assign MEM_WE = (state_q == StWb);
  assign MEM_RE = (state_q == StFill);
  assign BUSY   = (state_q != StIdle);
  assign DONE   = (state_q == StDone);
  assign ERR    = (state_q == StDone) && err_q;
  assign RLINE  = rline_q;

  always_comb begin
    MEM_ADDR = '0;
    MEM_DOUT = '0;
    unique case (state_q)
      StWb: begin
        MEM_ADDR = {2'b00, wb_base_q + 30'(beat_q)};
        MEM_DOUT = wline_q[beat_q];
      end
      StFill: begin
        MEM_ADDR = {2'b00, rd_base_q + 30'(beat_q)};
      end
      default: begin
        MEM_ADDR = '0;
        MEM_DOUT = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Directed bench for mem_burst_initiator with a delayed burst memory model (D=10, B=4).
module tb_mem_burst_initiator;
  localparam int BL  = 4;
  localparam int D   = 10;
  localparam int TMO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              req_read = 1'b0;
  logic              req_write = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       wb_addr = '0;
  logic [32*BL-1:0]  wline = '0;
  logic [32*BL-1:0]  rline;
  logic              busy, done, err, mem_re, mem_we;
  logic [31:0]       mem_addr, mem_dout, mem_din;
  logic              mem_valid = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  mem_burst_initiator #(
    .BURST_LEN      (BL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ_READ  (req_read),
    .REQ_WRITE (req_write),
    .REQ_ADDR  (req_addr),
    .WB_ADDR   (wb_addr),
    .WLINE     (wline),
    .RLINE     (rline),
    .BUSY      (busy),
    .DONE      (done),
    .ERR       (err),
    .MEM_RE    (mem_re),
    .MEM_WE    (mem_we),
    .MEM_ADDR  (mem_addr),
    .MEM_DOUT  (mem_dout),
    .MEM_DIN   (mem_din),
    .MEM_VALID (mem_valid)
  );

  // Memory model: samples a strobe, waits D edges, then streams BL beats.
  logic [31:0] mem [0:1023];
  int   m_wait   = 0;
  int   m_beats  = 0;
  logic m_armed  = 1'b1;
  logic mem_dead = 1'b0;

  always @(posedge clk) begin
    if (m_beats > 0) begin
      m_beats <= m_beats - 1;
      if (m_beats == 1) mem_valid <= 1'b0;
    end else if (m_wait > 0) begin
      if (m_wait == 1) begin
        mem_valid <= 1'b1;
        m_beats   <= BL;
      end
      m_wait <= m_wait - 1;
    end else if ((mem_re || mem_we) && m_armed && !mem_dead) begin
      m_wait  <= D;
      m_armed <= 1'b0;
    end
    if (!mem_re && !mem_we) m_armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (mem_valid && mem_we) mem[mem_addr[9:0]] <= mem_dout;
  end

  assign mem_din = mem_valid ? mem[mem_addr[9:0]] : 32'hDEAD_BEEF;

  // Monitors sampled away from the active edge.
  int          done_cnt = 0;
  int          gap_cnt = 0;
  int          overlap_cnt = 0;
  int          we_cnt = 0;
  int          re_cnt = 0;
  logic [31:0] rd_addrs[$];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy && !mem_re && !mem_we && !done) gap_cnt++;
    if (mem_re && mem_we) overlap_cnt++;
    if (mem_we) we_cnt++;
    if (mem_re) re_cnt++;
    if (mem_valid && mem_re) rd_addrs.push_back(mem_addr);
  end

  task automatic clear_mon();
    done_cnt = 0;
    gap_cnt = 0;
    overlap_cnt = 0;
    we_cnt = 0;
    re_cnt = 0;
    rd_addrs.delete();
  endtask

  // Presents a request for one edge (E0); returns at E0 + 1.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] ra,
                       input logic [31:0] wa, input logic [32*BL-1:0] wl);
    @(negedge clk);
    req_read = rd;
    req_write = wr;
    req_addr = ra;
    wb_addr = wa;
    wline = wl;
    @(posedge clk);
    #1;
    req_read = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic wait_done(output int n, input int limit);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_rd_addrs(input string tag, input logic [31:0] base);
    n_cmp++;
    if (rd_addrs.size() != BL) begin
      n_bad++;
      $display("FAIL %s_beats: got %0d read beats, want %0d", tag, rd_addrs.size(), BL);
    end else begin
      for (int i = 0; i < BL; i++) begin
        n_cmp++;
        if (rd_addrs[i] !== base + 32'(i)) begin
          n_bad++;
          $display("FAIL %s_addr%0d: got %h want %h", tag, i, rd_addrs[i], base + 32'(i));
        end
      end
    end
  endtask

  localparam logic [127:0] FillA = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] FillB = {32'h88, 32'h77, 32'h66, 32'h55};

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, err, mem_re, mem_we} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, mem_re, mem_we});
    end
    n_cmp++;
    if (rline !== '0 || mem_addr !== '0 || mem_dout !== '0) begin
      n_bad++;
      $display("FAIL reset_data: rline %h addr %h dout %h want all 0", rline, mem_addr, mem_dout);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    int n;
    clear_mon();
    issue(1'b1, 1'b0, 32'h400, 32'h0, '0);
    n_cmp++;
    if (busy !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_accept: busy %b re %b we %b want 1 1 0", busy, mem_re, mem_we);
    end
    wait_done(n, 40);
    n_cmp++;
    if (n != 15) begin
      n_bad++;
      $display("FAIL fill_latency: got %0d want 15", n);
    end
    n_cmp++;
    if (rline !== FillA || err !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_rline: got %h err %b want %h err 0", rline, err, FillA);
    end
    check_rd_addrs("fill", 32'h100);
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || done_cnt != 1 || gap_cnt != 0) begin
      n_bad++;
      $display("FAIL fill_end: busy %b done %b pulses %0d gaps %0d want 0 0 1 0",
               busy, done, done_cnt, gap_cnt);
    end
  endtask

  task automatic test_writeback();
    int n;
    clear_mon();
    issue(1'b0, 1'b1, 32'h0, 32'h800, {32'hD, 32'hC, 32'hB, 32'hA});
    n_cmp++;
    if (mem_we !== 1'b1 || mem_re !== 1'b0) begin
      n_bad++;
      $display("FAIL wb_accept: we %b re %b want 1 0", mem_we, mem_re);
    end
    wait_done(n, 40);
    n_cmp++;
    if (n != 15 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL wb_latency: got %0d err %b want 15 err 0", n, err);
    end
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < BL; i++) begin
      n_cmp++;
      if (mem[32'h200 + i] !== 32'hA + 32'(i)) begin
        n_bad++;
        $display("FAIL wb_mem%0d: got %h want %h", i, mem[32'h200 + i], 32'hA + 32'(i));
      end
    end
    n_cmp++;
    if (re_cnt != 0 || done_cnt != 1) begin
      n_bad++;
      $display("FAIL wb_side: re cycles %0d pulses %0d want 0 1", re_cnt, done_cnt);
    end
  endtask

  task automatic test_wb_fill();
    int n;
    clear_mon();
    issue(1'b1, 1'b1, 32'h400, 32'h800, {32'hD4, 32'hC3, 32'hB2, 32'hA1});
    wait_done(n, 60);
    n_cmp++;
    if (n != 31) begin
      n_bad++;
      $display("FAIL wbfill_latency: got %0d want 31", n);
    end
    n_cmp++;
    if (rline !== FillA || err !== 1'b0) begin
      n_bad++;
      $display("FAIL wbfill_rline: got %h err %b want %h err 0", rline, err, FillA);
    end
    check_rd_addrs("wbfill", 32'h100);
    n_cmp++;
    if (gap_cnt != 1 || overlap_cnt != 0) begin
      n_bad++;
      $display("FAIL wbfill_gap: gaps %0d overlaps %0d want 1 0", gap_cnt, overlap_cnt);
    end
    n_cmp++;
    if (mem[32'h200] !== 32'hA1 || mem[32'h203] !== 32'hD4) begin
      n_bad++;
      $display("FAIL wbfill_mem: got %h..%h want a1..d4", mem[32'h200], mem[32'h203]);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_timeout();
    int   n;
    logic re_before, re_at, err_at;
    clear_mon();
    mem_dead = 1'b1;
    n = -1;
    re_before = 1'b0;
    re_at = 1'b1;
    err_at = 1'b0;
    issue(1'b1, 1'b0, 32'h500, 32'h0, '0);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == TMO - 1) re_before = mem_re;
      if (done) begin
        n = i;
        re_at = mem_re;
        err_at = err;
        break;
      end
    end
    n_cmp++;
    if (n != TMO || re_before !== 1'b1 || re_at !== 1'b0 || err_at !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout: done@%0d re19 %b re20 %b err %b want 20 1 0 1",
               n, re_before, re_at, err_at);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || done_cnt != 1) begin
      n_bad++;
      $display("FAIL timeout_idle: busy %b done %b err %b pulses %0d want 0 0 0 1",
               busy, done, err, done_cnt);
    end
    n_cmp++;
    if (rline !== FillA) begin
      n_bad++;
      $display("FAIL timeout_rline: got %h want %h", rline, FillA);
    end
    mem_dead = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    clear_mon();
    issue(1'b1, 1'b0, 32'h400, 32'h0, '0);
    repeat (13) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, err, mem_re, mem_we} !== 5'b0 || rline !== '0 || mem_addr !== '0) begin
      n_bad++;
      $display("FAIL midrst_outs: ctrl %b rline %h addr %h want all 0",
               {busy, done, err, mem_re, mem_we}, rline, mem_addr);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    clear_mon();
    issue(1'b1, 1'b0, 32'h500, 32'h0, '0);
    wait_done(n, 40);
    n_cmp++;
    if (n != 15 || rline !== FillB || err !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_refill: done@%0d rline %h err %b want 15 %h 0", n, rline, err, FillB);
    end
    check_rd_addrs("midrst", 32'h140);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_busy_ignore();
    int n;
    clear_mon();
    issue(1'b1, 1'b0, 32'h40C, 32'h0, '0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    req_read = 1'b1;
    req_write = 1'b1;
    req_addr = 32'h500;
    wb_addr = 32'h800;
    @(posedge clk);
    #1;
    req_read = 1'b0;
    req_write = 1'b0;
    wait_done(n, 40);
    n_cmp++;
    if (n != 10 || rline !== FillA) begin
      n_bad++;
      $display("FAIL busy_fill: done@%0d rline %h want 10 %h", n, rline, FillA);
    end
    check_rd_addrs("busy", 32'h100);
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt != 1 || we_cnt != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_ignored: pulses %0d we cycles %0d busy %b want 1 0 0",
               done_cnt, we_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_mon();
    issue(1'b1, 1'b0, 32'h400, 32'h0, '0);
    wait_done(n, 40);
    req_read = 1'b1;
    req_addr = 32'h500;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: busy %b want 0", busy);
    end
    @(posedge clk);
    #1;
    req_read = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || mem_re !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: busy %b re %b want 1 1", busy, mem_re);
    end
    wait_done(n, 40);
    n_cmp++;
    if (n != 15 || rline !== FillB) begin
      n_bad++;
      $display("FAIL b2b_fill: done@%0d rline %h want 15 %h", n, rline, FillB);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt != 2) begin
      n_bad++;
      $display("FAIL b2b_pulses: got %0d want 2", done_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < BL; i++) begin
      mem[32'h100 + i] = 32'h11 * (i + 1);
      mem[32'h140 + i] = 32'h11 * (i + 5);
    end
    test_reset();
    test_fill();
    test_writeback();
    test_wb_fill();
    test_timeout();
    test_reset_mid_burst();
    test_busy_ignore();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
